// File: rtl/regbank_p4_arbiter_if.sv
// Instruction-port bundle shared by the requesting controllers and the register-bank arbiter.
// The requester-side signals and the bank-side signals travel together so one handle wires up a whole arbiter.
interface regbank_p4_arbiter_if #(
  parameter int NumReq = 4
);
  logic [NumReq-1:0]    req;
  logic [NumReq-1:0]    lock;
  logic [12*NumReq-1:0] inst;
  logic [NumReq-1:0]    ack;
  logic [NumReq-1:0]    rej;
  logic [11:0]          out_inst;
  logic                 out_inst_en;
  logic [1:0]           owner;
  logic                 locked;
  logic                 lock_expired;

  modport master (
    output req, lock, inst,
    input  ack, rej, out_inst, out_inst_en, owner, locked, lock_expired
  );

  modport slave (
    input  req, lock, inst,
    output ack, rej, out_inst, out_inst_en, owner, locked, lock_expired
  );
endinterface

// File: rtl/regbank_p4_arbiter.sv
// Round-robin arbiter for the 4-register bank's instruction port, with per-requester
// lock for atomic bursts, lock timeout, and an illegal-opcode filter.
module regbank_p4_arbiter #(
  parameter int NumReq      = 4,
  parameter int LockTimeout = 16
) (
  input logic                  clock,
  input logic                  reset,
  regbank_p4_arbiter_if.slave  bus
);

  typedef enum logic [1:0] {
    StReset = 2'd0,
    StReady = 2'd1
  } state_t;

  state_t             r_state;
  state_t             w_nextState;

  logic [1:0]         r_ptr;
  logic               r_locked;
  logic [1:0]         r_owner;
  logic [7:0]         r_count;
  logic [NumReq-1:0]  r_ack;
  logic [NumReq-1:0]  r_rej;
  logic [11:0]        r_outInst;
  logic               r_outInstEn;
  logic               r_lockExpired;

  logic [NumReq-1:0]  w_ownerMask;
  logic [NumReq-1:0]  w_eligible;
  logic               w_grantValid;
  logic [1:0]         w_grantIdx;
  logic [11:0]        w_grantInst;
  logic               w_legal;

  logic [1:0]         w_nPtr;
  logic               w_nLocked;
  logic [1:0]         w_nOwner;
  logic [7:0]         w_nCount;
  logic [NumReq-1:0]  w_nAck;
  logic [NumReq-1:0]  w_nRej;
  logic [11:0]        w_nOutInst;
  logic               w_nOutInstEn;
  logic               w_nLockExpired;

  always_ff @(posedge clock) begin
    if (reset) r_state <= StReset;
    else       r_state <= w_nextState;
  end

  always_comb begin
    w_nextState = StReset;
    case (r_state)
      StReset: w_nextState = StReady;
      StReady: w_nextState = StReady;
      default: w_nextState = StReset;
    endcase
  end

  // Registered ack/rej mask the requester that is still holding req during its pulse cycle.
  always_comb begin
    w_ownerMask          = '0;
    w_ownerMask[r_owner] = 1'b1;
  end

  assign w_eligible = bus.req & ~r_ack & ~r_rej & (r_locked ? w_ownerMask : '1);

  always_comb begin : scan
    logic [1:0] v_idx;
    v_idx        = '0;
    w_grantValid = 1'b0;
    w_grantIdx   = '0;
    for (int i = NumReq - 1; i >= 0; i--) begin
      v_idx = r_ptr + 2'(i);
      if (w_eligible[v_idx]) begin
        w_grantValid = 1'b1;
        w_grantIdx   = v_idx;
      end
    end
  end

  always_comb begin
    w_grantInst = '0;
    for (int k = 0; k < NumReq; k++) begin
      if (w_grantIdx == 2'(k)) w_grantInst = bus.inst[k*12 +: 12];
    end
  end

  assign w_legal = (w_grantInst[11:8] <= 4'd4);

  // Output process: next values of every registered output, only active in Ready.
  always_comb begin
    w_nPtr         = r_ptr;
    w_nLocked      = r_locked;
    w_nOwner       = r_owner;
    w_nCount       = '0;
    w_nAck         = '0;
    w_nRej         = '0;
    w_nOutInst     = r_outInst;
    w_nOutInstEn   = 1'b0;
    w_nLockExpired = 1'b0;
    if (r_state == StReady) begin
      if (w_grantValid) begin
        if (w_legal) begin
          w_nAck[w_grantIdx] = 1'b1;
          w_nOutInst         = w_grantInst;
          w_nOutInstEn       = 1'b1;
        end else begin
          w_nRej[w_grantIdx] = 1'b1;
        end
        w_nPtr = w_grantIdx + 2'd1;
        if (bus.lock[w_grantIdx]) begin
          w_nLocked = 1'b1;
          w_nOwner  = w_grantIdx;
        end else begin
          w_nLocked = 1'b0;
        end
      end else if (r_locked) begin
        if (r_count == 8'(LockTimeout - 1)) begin
          w_nLocked      = 1'b0;
          w_nLockExpired = 1'b1;
        end else begin
          w_nCount = r_count + 8'd1;
        end
      end
    end
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      r_ptr         <= '0;
      r_locked      <= 1'b0;
      r_owner       <= '0;
      r_count       <= '0;
      r_ack         <= '0;
      r_rej         <= '0;
      r_outInst     <= '0;
      r_outInstEn   <= 1'b0;
      r_lockExpired <= 1'b0;
    end else begin
      r_ptr         <= w_nPtr;
      r_locked      <= w_nLocked;
      r_owner       <= w_nOwner;
      r_count       <= w_nCount;
      r_ack         <= w_nAck;
      r_rej         <= w_nRej;
      r_outInst     <= w_nOutInst;
      r_outInstEn   <= w_nOutInstEn;
      r_lockExpired <= w_nLockExpired;
    end
  end

  assign bus.ack          = r_ack;
  assign bus.rej          = r_rej;
  assign bus.out_inst     = r_outInst;
  assign bus.out_inst_en  = r_outInstEn;
  assign bus.owner        = r_owner;
  assign bus.locked       = r_locked;
  assign bus.lock_expired = r_lockExpired;

endmodule

// File: tb/tb_regbank_p4_arbiter.sv
// Directed scenarios followed by randomized traffic, every cycle compared against a
// transaction-level reference model of the arbiter.
module tb_regbank_p4_arbiter;

  localparam int LockTimeout = 16;

  logic clock = 1'b0;
  logic reset = 1'b1;
  int   checks = 0;
  int   failures = 0;

  regbank_p4_arbiter_if #(.NumReq(4)) bus ();

  regbank_p4_arbiter #(.NumReq(4), .LockTimeout(LockTimeout)) dut (
    .clock (clock),
    .reset (reset),
    .bus   (bus)
  );

  always #5 clock = ~clock;

  // Reference model state: pointer, lock bookkeeping and expected registered outputs.
  int         mPtr, mOwner, mCount;
  bit         mLocked, mReady;
  logic [3:0] expAck, expRej;
  logic [11:0] expInst;
  logic       expEn, expExpired;

  task automatic modelStep(input logic rst);
    int win;
    logic [11:0] word;
    if (rst) begin
      mPtr = 0; mOwner = 0; mCount = 0; mLocked = 0; mReady = 0;
      expAck = '0; expRej = '0; expInst = '0; expEn = 0; expExpired = 0;
      return;
    end
    if (!mReady) begin
      mReady = 1;
      expAck = '0; expRej = '0; expEn = 0; expExpired = 0;
      return;
    end
    win = -1;
    for (int off = 0; off < 4; off++) begin
      int k;
      k = (mPtr + off) % 4;
      if (win < 0 && bus.req[k] && !expAck[k] && !expRej[k] && (!mLocked || k == mOwner))
        win = k;
    end
    expAck = '0; expRej = '0; expEn = 0; expExpired = 0;
    if (win >= 0) begin
      word = bus.inst[win*12 +: 12];
      if (word[11:8] <= 4) begin
        expAck[win] = 1'b1; expEn = 1'b1; expInst = word;
      end else begin
        expRej[win] = 1'b1;
      end
      mPtr = (win + 1) % 4;
      if (bus.lock[win]) begin mLocked = 1; mOwner = win; end
      else mLocked = 0;
      mCount = 0;
    end else if (mLocked) begin
      if (mCount == LockTimeout - 1) begin
        mLocked = 0; expExpired = 1; mCount = 0;
      end else begin
        mCount++;
      end
    end else begin
      mCount = 0;
    end
  endtask

  task automatic checkVal(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    assert (got === exp) else begin
      failures++;
      $error("[TB] FAIL %s observed=%0h expected=%0h", tag, got, exp);
    end
  endtask

  task automatic checkOutput();
    checkVal("ack", 32'(bus.ack), 32'(expAck));
    checkVal("rej", 32'(bus.rej), 32'(expRej));
    checkVal("out_inst_en", 32'(bus.out_inst_en), 32'(expEn));
    checkVal("out_inst", 32'(bus.out_inst), 32'(expInst));
    checkVal("locked", 32'(bus.locked), 32'(mLocked));
    checkVal("lock_expired", 32'(bus.lock_expired), 32'(expExpired));
    if (mLocked) checkVal("owner", 32'(bus.owner), 32'(mOwner));
  endtask

  task automatic applyStimulus(input logic [3:0] r, input logic [3:0] l,
                               input logic [11:0] i0, input logic [11:0] i1,
                               input logic [11:0] i2, input logic [11:0] i3);
    bus.req  = r;
    bus.lock = l;
    bus.inst = {i3, i2, i1, i0};
  endtask

  task automatic cycle();
    @(posedge clock);
    modelStep(reset);
    #1;
    checkOutput();
  endtask

  initial begin
    applyStimulus(4'b0000, 4'b0000, 12'h0, 12'h0, 12'h0, 12'h0);
    reset = 1'b1;
    cycle();
    cycle();
    checkVal("reset_ack", 32'(bus.ack), 32'd0);
    checkVal("reset_en", 32'(bus.out_inst_en), 32'd0);
    checkVal("reset_inst", 32'(bus.out_inst), 32'd0);

    // Single request: visible two edges after reset release, not repeated while held.
    reset = 1'b0;
    applyStimulus(4'b0001, 4'b0000, 12'h1A5, 12'h0, 12'h0, 12'h0);
    cycle();
    checkVal("t1_noGrantInReset", 32'(bus.ack), 32'd0);
    cycle();
    checkVal("t1_ack", 32'(bus.ack), 32'h1);
    checkVal("t1_en", 32'(bus.out_inst_en), 32'd1);
    checkVal("t1_inst", 32'(bus.out_inst), 32'h1A5);
    cycle();
    checkVal("t1_noRepeatAck", 32'(bus.ack), 32'd0);
    checkVal("t1_noRepeatEn", 32'(bus.out_inst_en), 32'd0);
    applyStimulus(4'b0000, 4'b0000, 12'h0, 12'h0, 12'h0, 12'h0);

    // All four requesting continuously from a fresh pointer.
    reset = 1'b1;
    cycle();
    reset = 1'b0;
    applyStimulus(4'b1111, 4'b0000, 12'h0A0, 12'h1A1, 12'h2A2, 12'h3A3);
    cycle();
    for (int i = 0; i < 8; i++) begin
      cycle();
      checkVal("t2_rrOrder", 32'(bus.ack), 32'(4'b0001 << (i % 4)));
    end

    // Illegal opcode rejected, then a legal one from the same requester forwarded.
    applyStimulus(4'b0100, 4'b0000, 12'h0, 12'h0, 12'h7FF, 12'h0);
    cycle();
    checkVal("t3_rej", 32'(bus.rej), 32'h4);
    checkVal("t3_enLow", 32'(bus.out_inst_en), 32'd0);
    checkVal("t3_instHeld", 32'(bus.out_inst), 32'h3A3);
    applyStimulus(4'b0100, 4'b0000, 12'h0, 12'h0, 12'h4C3, 12'h0);
    cycle();
    cycle();
    checkVal("t3_ack", 32'(bus.ack), 32'h4);
    checkVal("t3_inst", 32'(bus.out_inst), 32'h4C3);
    applyStimulus(4'b0000, 4'b0000, 12'h0, 12'h0, 12'h0, 12'h0);

    // Locked burst of three from requester 1 while requester 3 waits.
    reset = 1'b1;
    cycle();
    reset = 1'b0;
    applyStimulus(4'b1010, 4'b0010, 12'h0, 12'h100, 12'h0, 12'h300);
    cycle();
    cycle();
    checkVal("t4_burst0", 32'(bus.ack), 32'h2);
    checkVal("t4_locked", 32'(bus.locked), 32'd1);
    checkVal("t4_owner", 32'(bus.owner), 32'd1);
    applyStimulus(4'b1010, 4'b0010, 12'h0, 12'h101, 12'h0, 12'h300);
    cycle();
    checkVal("t4_waitWhileLocked", 32'(bus.ack), 32'd0);
    cycle();
    checkVal("t4_burst1", 32'(bus.ack), 32'h2);
    applyStimulus(4'b1010, 4'b0000, 12'h0, 12'h102, 12'h0, 12'h300);
    cycle();
    cycle();
    checkVal("t4_burst2", 32'(bus.ack), 32'h2);
    checkVal("t4_unlocked", 32'(bus.locked), 32'd0);
    applyStimulus(4'b1000, 4'b0000, 12'h0, 12'h0, 12'h0, 12'h300);
    cycle();
    checkVal("t4_req3Next", 32'(bus.ack), 32'h8);
    applyStimulus(4'b0000, 4'b0000, 12'h0, 12'h0, 12'h0, 12'h0);

    // Lock timeout: owner goes quiet, requester 2 waits for the forced release.
    applyStimulus(4'b0001, 4'b0001, 12'h200, 12'h0, 12'h0, 12'h0);
    cycle();
    checkVal("t5_lockSet", 32'(bus.locked), 32'd1);
    applyStimulus(4'b0100, 4'b0000, 12'h0, 12'h0, 12'h301, 12'h0);
    for (int i = 1; i < LockTimeout; i++) begin
      cycle();
      checkVal("t5_stillLocked", 32'(bus.locked), 32'd1);
    end
    cycle();
    checkVal("t5_expired", 32'(bus.lock_expired), 32'd1);
    checkVal("t5_released", 32'(bus.locked), 32'd0);
    cycle();
    checkVal("t5_req2Granted", 32'(bus.ack), 32'h4);
    applyStimulus(4'b0000, 4'b0000, 12'h0, 12'h0, 12'h0, 12'h0);

    // Reset right after a locking grant drops the pulses and the lock.
    applyStimulus(4'b0001, 4'b0001, 12'h111, 12'h0, 12'h0, 12'h0);
    cycle();
    checkVal("t6_preLocked", 32'(bus.locked), 32'd1);
    reset = 1'b1;
    cycle();
    checkVal("t6_ackDropped", 32'(bus.ack), 32'd0);
    checkVal("t6_lockCleared", 32'(bus.locked), 32'd0);
    reset = 1'b0;
    cycle();
    checkVal("t6_idleAfterReset", 32'(bus.ack), 32'd0);
    cycle();
    checkVal("t6_grantResumes", 32'(bus.ack), 32'h1);

    // Randomized traffic against the model, with occasional resets.
    for (int n = 0; n < 600; n++) begin
      logic [11:0] w [4];
      for (int k = 0; k < 4; k++) begin
        w[k] = 12'($urandom);
        if ($urandom_range(0, 3) != 0) w[k][11:8] = 4'($urandom_range(0, 4));
      end
      reset = ($urandom_range(0, 79) == 0);
      applyStimulus(4'($urandom), 4'($urandom) & 4'($urandom), w[0], w[1], w[2], w[3]);
      cycle();
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
